// File: rtl/data_memory_pkg.sv
//-----------------------------------------------------------------------------
// +---------------------------------------------------------------------------+
// | Module      : data_memory_pkg                                              |
// | Description : Shared types and default constants for the parameterised   |
// |               data memory: FSM state encoding, default geometry and the   |
// |               width of the wait-state down-counter.                       |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
//-----------------------------------------------------------------------------
`default_nettype none

package data_memory_pkg;

  // Default geometry of the memory.
  localparam int c_DATA_W_DEFAULT      = 16;
  localparam int c_ADDR_W_DEFAULT      = 16;
  localparam int c_DEPTH_DEFAULT       = 256;
  localparam int c_WAIT_STATES_DEFAULT = 1;

  // Wait states are limited to 0..15, so four bits cover the counter.
  localparam int c_WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage : data_memory_pkg

`default_nettype wire

// File: rtl/mem_array.sv
//-----------------------------------------------------------------------------
// +---------------------------------------------------------------------------+
// | Module      : mem_array                                                    |
// | Description : DEPTH x DATA_W storage with a byte-enable synchronous write  |
// |               port and a registered read port sharing one address. The    |
// |               contents are never reset.                                   |
// | Ports       : clock   - rising-edge clock                                 |
// |               wr_en   - write strobe (bytes gated by wr_be)                |
// |               wr_be   - per-byte write enable                             |
// |               wr_data - write word                                         |
// |               rd_en   - load rd_data from the addressed word              |
// |               addr    - word index                                         |
// |               rd_data - registered read word, held between reads          |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
//-----------------------------------------------------------------------------
`default_nettype none

module mem_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  input  logic [IDX_W-1:0]      addr,
  output logic [DATA_W-1:0]     rd_data
);

  localparam int c_BE_W = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < c_BE_W; i++) begin
        if (wr_be[i]) begin
          r_mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
    if (rd_en) begin
      r_rd_data <= r_mem[addr];
    end
  end

  assign rd_data = r_rd_data;

endmodule : mem_array

`default_nettype wire

// File: rtl/param_data_memory.sv
//-----------------------------------------------------------------------------
// +---------------------------------------------------------------------------+
// | Module      : param_data_memory                                            |
// | Description : Request/response data memory with a programmable number of  |
// |               wait states, byte-enable writes and out-of-range error      |
// |               reporting. Storage lives in mem_array; this level holds the |
// |               IDLE/WAIT/RESP sequencer and the response outputs.          |
// | Ports       : clock, reset (sync, active high)                            |
// |               req_valid/req_ready handshake, req_write, address,          |
// |               write_data, byte_en                                          |
// |               resp_valid strobe, read_data, resp_error                    |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
//-----------------------------------------------------------------------------
`default_nettype none

module param_data_memory
  import data_memory_pkg::*;
#(
  parameter int DATA_W      = c_DATA_W_DEFAULT,
  parameter int ADDR_W      = c_ADDR_W_DEFAULT,
  parameter int DEPTH       = c_DEPTH_DEFAULT,
  parameter int WAIT_STATES = c_WAIT_STATES_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     write_data,
  input  logic [DATA_W/8-1:0]   byte_en,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     read_data,
  output logic                  resp_error
);

  localparam int c_BE_W  = DATA_W / 8;
  localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // The counter is loaded with WAIT_STATES-1 on acceptance so that WAIT
  // lasts exactly WAIT_STATES cycles (the zero-count cycle included).
  localparam logic [c_WAIT_CNT_W-1:0] c_WAIT_LOAD =
    (WAIT_STATES > 0) ? c_WAIT_CNT_W'(WAIT_STATES - 1) : '0;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [c_WAIT_CNT_W-1:0] r_wait_cnt;
  logic [c_WAIT_CNT_W-1:0] w_wait_cnt_nxt;
  logic                    w_ready;
  logic                    w_access;
  logic                    w_accept;

  logic                    r_req_write;
  logic [ADDR_W-1:0]       r_addr;
  logic [DATA_W-1:0]       r_wdata;
  logic [c_BE_W-1:0]       r_be;

  logic                    w_acc_write;
  logic [ADDR_W-1:0]       w_acc_addr;
  logic [DATA_W-1:0]       w_acc_wdata;
  logic [c_BE_W-1:0]       w_acc_be;
  logic                    w_in_range;
  logic                    w_do_access;

  logic                    r_err;
  logic                    r_rd_zero;
  logic [DATA_W-1:0]       w_mem_rd;

  assign req_ready = w_ready & ~reset;
  assign w_accept  = req_valid & req_ready;

  //--------------------------------------------------------------------------
  // Next-state logic
  //--------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_ready        = 1'b0;
    w_access       = 1'b0;
    case (r_state)
      ST_IDLE, ST_RESP: begin
        w_ready = 1'b1;
        if (req_valid) begin
          if (WAIT_STATES == 0) begin
            // Zero wait states: the access happens on the accepting edge.
            w_state_nxt = ST_RESP;
            w_access    = 1'b1;
          end else begin
            w_state_nxt    = ST_WAIT;
            w_wait_cnt_nxt = c_WAIT_LOAD;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_wait_cnt == '0) begin
          w_access    = 1'b1;
          w_state_nxt = ST_RESP;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // With zero wait states the access uses the live request; otherwise it
  // uses the copy latched at acceptance.
  assign w_acc_write = (WAIT_STATES == 0) ? req_write  : r_req_write;
  assign w_acc_addr  = (WAIT_STATES == 0) ? address    : r_addr;
  assign w_acc_wdata = (WAIT_STATES == 0) ? write_data : r_wdata;
  assign w_acc_be    = (WAIT_STATES == 0) ? byte_en    : r_be;

  // Full-width compare so that out-of-range addresses never alias.
  assign w_in_range  = (32'(w_acc_addr) < 32'(DEPTH));
  // Reset wins over an access on the same edge.
  assign w_do_access = w_access & ~reset;

  //--------------------------------------------------------------------------
  // Control registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
      r_rd_zero  <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_do_access) begin
        r_err <= ~w_in_range;
        // read_data masks the storage output until an in-range read
        // reloads it; write responses leave it untouched.
        if (!w_acc_write) begin
          r_rd_zero <= ~w_in_range;
        end
      end
    end
  end

  // Request capture needs no reset: it is only consumed after acceptance.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_req_write <= req_write;
      r_addr      <= address;
      r_wdata     <= write_data;
      r_be        <= byte_en;
    end
  end

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (c_IDX_W)
  ) u_mem_array (
    .clock   (clock),
    .wr_en   (w_do_access & w_acc_write & w_in_range),
    .wr_be   (w_acc_be),
    .wr_data (w_acc_wdata),
    .rd_en   (w_do_access & ~w_acc_write & w_in_range),
    .addr    (w_acc_addr[c_IDX_W-1:0]),
    .rd_data (w_mem_rd)
  );

  //--------------------------------------------------------------------------
  // Outputs
  //--------------------------------------------------------------------------
  assign resp_valid = (r_state == ST_RESP) & ~reset;
  assign resp_error = resp_valid & r_err;
  assign read_data  = (reset | r_rd_zero) ? '0 : w_mem_rd;

endmodule : param_data_memory

`default_nettype wire

// File: tb/tb_param_data_memory.sv
//-----------------------------------------------------------------------------
// +---------------------------------------------------------------------------+
// | Module      : tb_param_data_memory                                         |
// | Description : Self-checking bench driving one request stream into two    |
// |               memories (WAIT_STATES=1 and WAIT_STATES=0), each compared   |
// |               cycle by cycle against its own transaction-level model.     |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
//-----------------------------------------------------------------------------
`default_nettype none

module tb_param_data_memory;

  logic             clock = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_write;
  logic [15:0]      address;
  logic [15:0]      write_data;
  logic [1:0]       byte_en;
  logic [1:0]       req_ready;
  logic [1:0]       resp_valid;
  logic [1:0]       resp_error;
  logic [1:0][15:0] read_data;

  always #5 clock = ~clock;

  param_data_memory #(.WAIT_STATES(1)) u_dut_ws1 (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready[0]),
    .req_write  (req_write),
    .address    (address),
    .write_data (write_data),
    .byte_en    (byte_en),
    .resp_valid (resp_valid[0]),
    .read_data  (read_data[0]),
    .resp_error (resp_error[0])
  );

  param_data_memory #(.WAIT_STATES(0)) u_dut_ws0 (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready[1]),
    .req_write  (req_write),
    .address    (address),
    .write_data (write_data),
    .byte_en    (byte_en),
    .resp_valid (resp_valid[1]),
    .read_data  (read_data[1]),
    .resp_error (resp_error[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Transaction-level model per DUT: memory image, the cycle the block is
  // free again, the pending request and the cycle of its response.
  logic [15:0] mem_m [2][256];
  int          free_at [2];
  int          resp_at [2];
  int          acc_at  [2];
  bit          p_write [2];
  int          p_addr  [2];
  logic [15:0] p_data  [2];
  logic [1:0]  p_be    [2];
  logic [15:0] exp_rd  [2];
  bit          exp_err [2];
  bit          window;
  int          pulses  [2];

  function automatic int ws_of(int k);
    return (k == 0) ? 1 : 0;
  endfunction

  function automatic void apply_write(int k);
    if (p_addr[k] < 256) begin
      for (int b = 0; b < 2; b++) begin
        if (p_be[k][b]) mem_m[k][p_addr[k]][8*b +: 8] = p_data[k][8*b +: 8];
      end
    end
  endfunction

  function automatic void complete(int k);
    exp_err[k] = (p_addr[k] >= 256);
    if (p_write[k]) apply_write(k);
    else exp_rd[k] = (p_addr[k] < 256) ? mem_m[k][p_addr[k]] : 16'h0000;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d cyc=%0d observed=%0h expected=%0h", tag, k, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare the cycle's outputs with the
  // model, record acceptance, advance to the next cycle.
  task automatic cycle(input bit rst, input bit v, input bit w, input int a,
                       input logic [15:0] d, input logic [1:0] be);
    bit e_ready;
    bit e_valid;
    reset      = rst;
    req_valid  = v;
    req_write  = w;
    address    = 16'(a);
    write_data = d;
    byte_en    = be;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        // Accesses already performed before this edge survive; later ones
        // are discarded, and no response appears.
        if (resp_at[k] >= cyc && acc_at[k] < cyc && p_write[k]) apply_write(k);
        resp_at[k] = -1;
        free_at[k] = cyc + 1;
        exp_rd[k]  = 16'h0000;
        e_ready    = 1'b0;
        e_valid    = 1'b0;
      end else begin
        e_valid = (resp_at[k] == cyc);
        if (e_valid) complete(k);
        e_ready = (cyc >= free_at[k]);
      end
      chk("req_ready", k, 32'(req_ready[k]), 32'(e_ready));
      chk("resp_valid", k, 32'(resp_valid[k]), 32'(e_valid));
      chk("resp_error", k, 32'(resp_error[k]), 32'(e_valid & exp_err[k]));
      chk("read_data", k, 32'(read_data[k]), 32'(exp_rd[k]));
      if (window && resp_valid[k]) pulses[k]++;
      if (!rst && v && e_ready) begin
        p_write[k] = w;
        p_addr[k]  = a;
        p_data[k]  = d;
        p_be[k]    = be;
        acc_at[k]  = cyc + ws_of(k);
        resp_at[k] = cyc + ws_of(k) + 1;
        free_at[k] = cyc + ws_of(k) + 1;
      end
    end
    @(negedge clock);
    cyc++;
  endtask

  task automatic req(input bit w, input int a, input logic [15:0] d,
                     input logic [1:0] be);
    cycle(0, 1, w, a, d, be);
    cycle(0, 0, 0, 0, 16'h0, 2'b00);
    cycle(0, 0, 0, 0, 16'h0, 2'b00);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    address = '0; write_data = '0; byte_en = '0;
    window = 1'b0;
    for (int k = 0; k < 2; k++) begin
      free_at[k] = 0; resp_at[k] = -1; acc_at[k] = -1;
      exp_rd[k] = 16'h0000; exp_err[k] = 1'b0; pulses[k] = 0;
      p_write[k] = 1'b0; p_addr[k] = 0; p_data[k] = '0; p_be[k] = '0;
    end
    @(negedge clock);
    cycle(1, 0, 0, 0, 16'h0, 2'b00);
    cycle(1, 1, 1, 3, 16'hFFFF, 2'b11);

    // Fill every word so later reads are fully predictable.
    for (int i = 0; i < 256; i++) req(1, i, 16'($urandom), 2'b11);

    // Full write then read back; partial write touches low byte only.
    req(1, 5, 16'h333C, 2'b11);
    req(0, 5, 16'h0, 2'b00);
    req(1, 5, 16'hAAAA, 2'b01);
    req(0, 5, 16'h0, 2'b00);
    req(1, 5, 16'h5555, 2'b00);
    req(0, 5, 16'h0, 2'b00);

    // Out-of-range write and read, then word 0 untouched.
    req(1, 256, 16'h1111, 2'b11);
    req(0, 256, 16'h0, 2'b00);
    req(0, 0, 16'h0, 2'b00);
    req(0, 16'hFFFF, 16'h0, 2'b00);

    // Back-to-back reads with req_valid held high.
    window = 1'b1;
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 20 + i, 16'h0, 2'b00);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 16'h0, 2'b00);
    window = 1'b0;
    chk("burst_pulses", 0, 32'(pulses[0]), 32'd4);
    chk("burst_pulses", 1, 32'(pulses[1]), 32'd8);

    // Reset right after accepting a write.
    cycle(0, 1, 1, 7, 16'h1234, 2'b11);
    cycle(1, 0, 0, 0, 16'h0, 2'b00);
    cycle(0, 0, 0, 0, 16'h0, 2'b00);
    req(0, 7, 16'h0, 2'b00);

    // Randomised traffic with occasional resets and zero-gap requests.
    for (int n = 0; n < 400; n++) begin
      int a;
      a = ($urandom_range(0, 9) == 0) ? int'($urandom_range(256, 65535))
                                      : int'($urandom_range(0, 255));
      if ($urandom_range(0, 49) == 0) begin
        cycle(1, 1, 1, a, 16'($urandom), 2'b11);
      end else begin
        cycle(0, 1, $urandom_range(0, 1) == 1, a, 16'($urandom), 2'($urandom));
      end
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
        cycle(0, 0, 0, 0, 16'h0, 2'b00);
      end
    end
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 16'h0, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_param_data_memory

`default_nettype wire
